// File: rtl/ddr_mem_burst_responder_pkg.sv
// Shared types for the DRAM-side CAS-to-data burst responder.
//   rw_type     : CAS direction, READ=0 / WRITE=1
//   dq_fsm_type : data-bus state machine states
//   cmd_t       : pending command entry {rw, col, due}
//   is_before() : wrap-aware "a earlier than b" on the 8-bit cycle counter
package ddr_package;

  localparam int unsigned NOW_W     = 8;   // width of the free-running cycle counter
  localparam int unsigned CMD_COL_W = 16;  // widest column address a cmd_t can carry

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rw_type;

  typedef enum logic [1:0] {
    DQ_IDLE = 2'd0,
    DQ_RD   = 2'd1,
    DQ_WR   = 2'd2
  } dq_fsm_type;

  typedef struct packed {
    rw_type                 rw;
    logic [CMD_COL_W-1:0]   col;
    logic [NOW_W-1:0]       due;
  } cmd_t;

  // (a - b) read as a signed NOW_W-bit value is negative
  function automatic logic is_before(input logic [NOW_W-1:0] a,
                                     input logic [NOW_W-1:0] b);
    logic [NOW_W-1:0] d;
    d = a - b;
    return d[NOW_W-1];
  endfunction

endpackage

// File: rtl/ddr_mem_burst_responder_if.sv
// Command/data bus between a memory controller (master) and the DRAM-side
// burst responder (slave).
//   cas_valid/cas_rw/cas_col : CAS command, one per cycle at most
//   wr_dq/wr_dq_valid        : two write beats per cycle {beat 2k+1, beat 2k}
//   rd_dq/rd_dq_valid        : two read beats per cycle, registered
//   busy                     : commands pending or data bus active
//   err_*                    : single-cycle protocol violation pulses
interface ddr_mem_burst_responder_if
  import ddr_package::*;
#(
  parameter int unsigned DQ_W  = 8,
  parameter int unsigned COL_W = 6
);

  logic              cas_valid;
  rw_type            cas_rw;
  logic [COL_W-1:0]  cas_col;
  logic [2*DQ_W-1:0] wr_dq;
  logic              wr_dq_valid;
  logic [2*DQ_W-1:0] rd_dq;
  logic              rd_dq_valid;
  logic              busy;
  logic              err_overflow;
  logic              err_collision;
  logic              err_wr_missing;

  modport master (
    output cas_valid, cas_rw, cas_col, wr_dq, wr_dq_valid,
    input  rd_dq, rd_dq_valid, busy, err_overflow, err_collision, err_wr_missing
  );

  modport slave (
    input  cas_valid, cas_rw, cas_col, wr_dq, wr_dq_valid,
    output rd_dq, rd_dq_valid, busy, err_overflow, err_collision, err_wr_missing
  );

endinterface

// File: rtl/ddr_mem_burst_responder_fifo.sv
// burst_cmd_fifo: in-order queue of pending CAS commands.
//   i_clk, i_rst : clock, synchronous active-high flush
//   i_push/i_din : enqueue; accepted when not full, or when full and popping
//   i_pop        : dequeue the head (ignored when empty)
//   o_head       : current head entry
//   o_full/o_empty
module burst_cmd_fifo
  import ddr_package::*;
#(
  parameter int unsigned QDEPTH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  cmd_t i_din,
  input  logic i_pop,
  output cmd_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  cmd_t             r_mem [QDEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(QDEPTH));
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(QDEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_do_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(QDEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_push && !w_do_pop)
        r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_do_push)
      r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/ddr_mem_burst_responder.sv
// ddr_mem_burst_responder: memory-side end of the CAS-to-data burst protocol.
// Queues CAS commands with due times, drives read bursts RL=AL+CL cycles and
// samples write bursts WL=AL+CWL cycles after the CAS, holds a column-addressed
// burst array, and flags controller timing violations.
//   clock_t : sole clock, rising edge
//   reset   : synchronous active-high; array contents survive it
//   bus     : slave side of ddr_mem_burst_responder_if
module ddr_mem_burst_responder
  import ddr_package::*;
#(
  parameter int unsigned DQ_W   = 8,
  parameter int unsigned BL     = 8,
  parameter int unsigned CL     = 11,
  parameter int unsigned CWL    = 9,
  parameter int unsigned AL     = 0,
  parameter int unsigned COL_W  = 6,
  parameter int unsigned QDEPTH = 8
) (
  input  logic                     clock_t,
  input  logic                     reset,
  ddr_mem_burst_responder_if.slave bus
);

  localparam int unsigned RL     = AL + CL;
  localparam int unsigned WL     = AL + CWL;
  localparam int unsigned NBEAT  = BL / 2;              // bus cycles per burst
  localparam int unsigned BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int unsigned SLICE  = 2 * DQ_W;
  localparam int unsigned WORD_W = BL * DQ_W;

  if (RL < 2 || WL < 2) begin : g_bad_latency
    $error("ddr_mem_burst_responder: RL and WL must both be at least 2");
  end
  if (COL_W > CMD_COL_W) begin : g_bad_col
    $error("ddr_mem_burst_responder: COL_W exceeds cmd_t column field");
  end

  logic [NOW_W-1:0]  r_now;
  logic [NOW_W-1:0]  r_busy_until;
  dq_fsm_type        r_state;
  dq_fsm_type        w_state_nxt;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] w_beat_nxt;

  logic [WORD_W-1:0] r_mem [2**COL_W];
  logic [WORD_W-1:0] r_rd_word;
  logic [WORD_W-1:0] r_wr_stage;
  logic [WORD_W-1:0] w_rd_src;
  logic [WORD_W-1:0] w_stage_nxt;
  logic [COL_W-1:0]  r_col;
  logic [COL_W-1:0]  w_wr_col;
  logic [COL_W-1:0]  w_head_col;
  logic              r_wr_ok;
  logic              w_wr_ok_nxt;
  logic              w_wr_sample;
  logic              w_commit;

  logic [SLICE-1:0]  r_rd_dq;
  logic [SLICE-1:0]  w_rd_dq_nxt;
  logic              r_rd_valid;
  logic              r_err_ovf;
  logic              r_err_col;
  logic              r_err_miss;

  cmd_t              w_head;
  cmd_t              w_new;
  logic              w_empty;
  logic              w_full;
  logic              w_active;
  logic              w_last;
  logic              w_pop;
  logic              w_push;
  logic              w_collide;
  logic              w_overflow;
  logic [NOW_W-1:0]  w_due_new;

  // ---------------- command acceptance ----------------
  assign w_active   = (r_state != DQ_IDLE);
  assign w_last     = w_active && (r_beat == BEAT_W'(NBEAT - 1));
  assign w_head_col = COL_W'(w_head.col);
  assign w_pop      = !w_empty && (w_head.due == r_now) && (!w_active || w_last);
  assign w_due_new  = r_now + ((bus.cas_rw == WRITE) ? NOW_W'(WL) : NOW_W'(RL));

  // busy_until is only meaningful while something is pending or on the bus;
  // when fully idle it may be stale by more than half the counter range.
  assign w_collide  = (!w_empty || w_active) && is_before(w_due_new, r_busy_until);
  assign w_overflow = bus.cas_valid && w_full && !w_pop;
  assign w_push     = bus.cas_valid && !w_overflow && !w_collide;

  assign w_new.rw  = bus.cas_rw;
  assign w_new.col = CMD_COL_W'(bus.cas_col);
  assign w_new.due = w_due_new;

  burst_cmd_fifo #(
    .QDEPTH (QDEPTH)
  ) u_cmd_fifo (
    .i_clk   (clock_t),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_din   (w_new),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ---------------- data bus FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    if (w_pop) begin
      w_state_nxt = (w_head.rw == WRITE) ? DQ_WR : DQ_RD;
      w_beat_nxt  = '0;
    end else if (w_last) begin
      w_state_nxt = DQ_IDLE;
      w_beat_nxt  = '0;
    end else if (w_active) begin
      w_beat_nxt  = r_beat + 1'b1;
    end
  end

  // ---------------- data bus FSM: beat datapath ----------------
  // Outputs are registered, so the beat selected here is the one for the
  // cycle after this edge (w_beat_nxt), not the current r_beat.
  always_comb begin
    w_rd_src    = w_pop ? r_mem[w_head_col] : r_rd_word;
    w_rd_dq_nxt = '0;
    w_stage_nxt = r_wr_stage;
    for (int unsigned k = 0; k < NBEAT; k++) begin
      if (w_beat_nxt == BEAT_W'(k)) begin
        if (w_state_nxt == DQ_RD)
          w_rd_dq_nxt = w_rd_src[k*SLICE +: SLICE];
        w_stage_nxt[k*SLICE +: SLICE] = bus.wr_dq;
      end
    end
    w_wr_sample = (w_state_nxt == DQ_WR);
    w_wr_ok_nxt = ((w_beat_nxt == '0) ? 1'b1 : r_wr_ok) & bus.wr_dq_valid;
    w_wr_col    = w_pop ? w_head_col : r_col;
    w_commit    = w_wr_sample && (w_beat_nxt == BEAT_W'(NBEAT - 1)) && w_wr_ok_nxt;
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      r_now        <= '0;
      r_busy_until <= '0;
      r_state      <= DQ_IDLE;
      r_beat       <= '0;
      r_rd_dq      <= '0;
      r_rd_valid   <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_col    <= 1'b0;
      r_err_miss   <= 1'b0;
      r_wr_ok      <= 1'b0;
      r_col        <= '0;
    end else begin
      r_now      <= r_now + 1'b1;
      if (w_push)
        r_busy_until <= w_due_new + NOW_W'(NBEAT);
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_rd_valid <= (w_state_nxt == DQ_RD);
      r_rd_dq    <= w_rd_dq_nxt;
      r_err_ovf  <= w_overflow;
      r_err_col  <= bus.cas_valid && !w_overflow && w_collide;
      r_err_miss <= w_wr_sample && !bus.wr_dq_valid;
      if (w_wr_sample)
        r_wr_ok <= w_wr_ok_nxt;
      r_col      <= w_wr_col;
    end
  end

  // Read word is captured once at burst start; write staging and the array
  // carry no reset so stored data survives a controller reset.
  always_ff @(posedge clock_t) begin
    r_rd_word <= w_rd_src;
    if (w_wr_sample)
      r_wr_stage <= w_stage_nxt;
    if (!reset && w_commit)
      r_mem[w_wr_col] <= w_stage_nxt;
  end

  assign bus.rd_dq          = r_rd_dq;
  assign bus.rd_dq_valid    = r_rd_valid;
  assign bus.busy           = !w_empty || w_active;
  assign bus.err_overflow   = r_err_ovf;
  assign bus.err_collision  = r_err_col;
  assign bus.err_wr_missing = r_err_miss;

endmodule

// File: tb/tb_ddr_mem_burst_responder.sv
module tb_ddr_mem_burst_responder;
  import ddr_package::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_mem_burst_responder_if #(.DQ_W(8), .COL_W(6)) bus_a ();
  ddr_mem_burst_responder_if #(.DQ_W(8), .COL_W(6)) bus_b ();

  // Main instance with the reference timing.
  ddr_mem_burst_responder #(
    .DQ_W(8), .BL(8), .CL(11), .CWL(9), .AL(0), .COL_W(6), .QDEPTH(8)
  ) u_dut (
    .clock_t (clk),
    .reset   (rst),
    .bus     (bus_a.slave)
  );

  // Additive latency 24 (RL=35, WL=33) so eight bursts can queue up before
  // the first one retires.
  ddr_mem_burst_responder #(
    .DQ_W(8), .BL(8), .CL(11), .CWL(9), .AL(24), .COL_W(6), .QDEPTH(8)
  ) u_dut_al (
    .clock_t (clk),
    .reset   (rst),
    .bus     (bus_b.slave)
  );

  typedef struct {
    int          cyc;
    int          kind;   // 0 read beat, 1 collision, 2 overflow, 3 missing write beat
    logic [15:0] data;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_ev(input string tag, input ev_t e, input int kind,
                                 input int t, input logic [15:0] d);
    checks++;
    if (e.kind != kind || e.cyc != t || e.data !== d) begin
      errors++;
      $display("FAIL %s event: got kind %0d cyc %0d data %h, want kind %0d cyc %0d data %h",
               tag, kind, t, d, e.kind, e.cyc, e.data);
    end
  endfunction

  function automatic void expect_ev(input bit alt, input int t, input int kind, input logic [15:0] d);
    ev_t e;
    e.cyc = t; e.kind = kind; e.data = d;
    if (alt) q_b.push_back(e);
    else     q_a.push_back(e);
  endfunction

  function automatic void expect_burst(input bit alt, input int t0, input logic [63:0] w,
                                       input int nbeats);
    for (int k = 0; k < nbeats; k++)
      expect_ev(alt, t0 + k, 0, w[16*k +: 16]);
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    logic [3:0] f;
    if (mon_en) begin
      f = {bus_a.err_wr_missing, bus_a.err_overflow, bus_a.err_collision, bus_a.rd_dq_valid};
      for (int k = 0; k < 4; k++) begin
        if (f[k]) begin
          if (q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL A unexpected event: got kind %0d at cyc %0d, want none", k, cyc);
          end else begin
            chk_ev("A", q_a.pop_front(), k, cyc, (k == 0) ? bus_a.rd_dq : 16'h0000);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [3:0] f;
    if (mon_en) begin
      f = {bus_b.err_wr_missing, bus_b.err_overflow, bus_b.err_collision, bus_b.rd_dq_valid};
      for (int k = 0; k < 4; k++) begin
        if (f[k]) begin
          if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL B unexpected event: got kind %0d at cyc %0d, want none", k, cyc);
          end else begin
            chk_ev("B", q_b.pop_front(), k, cyc, (k == 0) ? bus_b.rd_dq : 16'h0000);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return just after edge t; inputs set afterwards are sampled at edge t+1.
  task automatic wait_cyc(input int t);
    if (cyc > t) begin
      checks++; errors++;
      $display("FAIL schedule: got cyc %0d, want at most %0d", cyc, t);
    end
    while (cyc < t) tick();
  endtask

  task automatic cas(input bit alt, input int t, input rw_type rw, input logic [5:0] col);
    wait_cyc(t - 1);
    if (alt) begin bus_b.cas_valid = 1'b1; bus_b.cas_rw = rw; bus_b.cas_col = col; end
    else     begin bus_a.cas_valid = 1'b1; bus_a.cas_rw = rw; bus_a.cas_col = col; end
    tick();
    bus_a.cas_valid = 1'b0;
    bus_b.cas_valid = 1'b0;
  endtask

  task automatic wbeats(input bit alt, input int t0, input logic [63:0] w, input logic [3:0] vm);
    for (int k = 0; k < 4; k++) begin
      wait_cyc(t0 + k - 1);
      if (alt) begin bus_b.wr_dq = w[16*k +: 16]; bus_b.wr_dq_valid = vm[k]; end
      else     begin bus_a.wr_dq = w[16*k +: 16]; bus_a.wr_dq_valid = vm[k]; end
    end
    tick();
    bus_a.wr_dq_valid = 1'b0;
    bus_b.wr_dq_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin : stim
    int b;
    int b0;
    int guard;
    logic [63:0] w3;
    logic [63:0] wa;
    logic [63:0] wb;
    logic [63:0] wc;

    w3 = 64'h0706_0504_0302_0100;
    wa = 64'h1716_1514_1312_1110;
    wb = 64'h2726_2524_2322_2120;
    wc = 64'h3736_3534_3332_3130;

    bus_a.cas_valid = 1'b0; bus_a.cas_rw = READ; bus_a.cas_col = '0;
    bus_a.wr_dq = '0; bus_a.wr_dq_valid = 1'b0;
    bus_b.cas_valid = 1'b0; bus_b.cas_rw = READ; bus_b.cas_col = '0;
    bus_b.wr_dq = '0; bus_b.wr_dq_valid = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    chk("rst_rd_valid", 32'(bus_a.rd_dq_valid), 32'd0);
    chk("rst_rd_dq",    32'(bus_a.rd_dq), 32'd0);
    chk("rst_busy",     32'(bus_a.busy), 32'd0);
    chk("rst_errs",     32'({bus_a.err_overflow, bus_a.err_collision, bus_a.err_wr_missing}), 32'd0);
    chk("rst_busy_al",  32'(bus_b.busy), 32'd0);

    // Single write col 3, then read it back
    b = cyc + 2;
    expect_burst(1'b0, b + 31, w3, 4);
    cas(1'b0, b, WRITE, 6'd3);
    wbeats(1'b0, b + 9, w3, 4'b1111);
    cas(1'b0, b + 20, READ, 6'd3);
    wait_cyc(b + 36);

    // Back-to-back reads: 8 continuous beats, busy drops after them
    b = cyc + 2;
    expect_burst(1'b0, b + 11, w3, 4);
    expect_burst(1'b0, b + 15, w3, 4);
    cas(1'b0, b, READ, 6'd3);
    cas(1'b0, b + 4, READ, 6'd3);
    wait_cyc(b + 18);
    chk("b2b_busy_last", 32'(bus_a.busy), 32'd1);
    wait_cyc(b + 19);
    chk("b2b_busy_end", 32'(bus_a.busy), 32'd0);
    wait_cyc(b + 22);

    // Collision: second read dropped, only one burst occurs
    b = cyc + 2;
    expect_ev(1'b0, b + 2, 1, 16'h0000);
    expect_burst(1'b0, b + 11, w3, 4);
    cas(1'b0, b, READ, 6'd3);
    cas(1'b0, b + 2, READ, 6'd3);
    wait_cyc(b + 14);
    chk("col_busy_burst", 32'(bus_a.busy), 32'd1);
    wait_cyc(b + 15);
    chk("col_busy_idle", 32'(bus_a.busy), 32'd0);
    wait_cyc(b + 20);

    // Missing write beat: second write to col 5 is discarded
    b = cyc + 2;
    expect_ev(1'b0, b + 31, 3, 16'h0000);
    expect_burst(1'b0, b + 51, wa, 4);
    cas(1'b0, b, WRITE, 6'd5);
    wbeats(1'b0, b + 9, wa, 4'b1111);
    cas(1'b0, b + 20, WRITE, 6'd5);
    wbeats(1'b0, b + 29, wb, 4'b1011);
    cas(1'b0, b + 40, READ, 6'd5);
    wait_cyc(b + 56);

    // Reset in the middle of a read burst
    b = cyc + 2;
    expect_burst(1'b0, b + 11, w3, 3);
    cas(1'b0, b, READ, 6'd3);
    wait_cyc(b + 13);
    rst = 1'b1;
    tick();
    chk("mid_rst_rd_valid", 32'(bus_a.rd_dq_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus_a.busy), 32'd0);
    rst = 1'b0;
    b = cyc - 14;
    expect_burst(1'b0, b + 31, w3, 4);
    cas(1'b0, b + 20, READ, 6'd3);
    wait_cyc(b + 36);

    // Overflow on the AL=24 instance: ninth queued read is dropped
    b0 = cyc + 2;
    cas(1'b1, b0, WRITE, 6'd1);
    wbeats(1'b1, b0 + 33, wc, 4'b1111);
    b = b0 + 40;
    expect_ev(1'b1, b + 32, 2, 16'h0000);
    for (int i = 0; i < 8; i++)
      expect_burst(1'b1, b + 35 + 4*i, wc, 4);
    for (int i = 0; i < 9; i++)
      cas(1'b1, b + 4*i, READ, 6'd1);
    wait_cyc(b + 66);
    chk("ovf_busy_last", 32'(bus_b.busy), 32'd1);
    wait_cyc(b + 67);
    chk("ovf_busy_end", 32'(bus_b.busy), 32'd0);

    guard = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    repeat (4) tick();
    chk("drain_a", 32'(q_a.size()), 32'd0);
    chk("drain_b", 32'(q_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by cyc %0d, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
